// File: rtl/memory_unit.sv
// Word-addressed 32-bit memory with a programmable wait-state count and a
// busy/done request handshake that re-arms only after the request drops.
module memory_unit #(
   parameter int ADDR_W = 9,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MAR,
   input  logic [31:0] MDR,
   input  logic        Read,
   input  logic        Write,
   output logic [31:0] Mdatain,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         data_q;
   logic                op_read;
   logic                commit_write;
   logic                unused_mar_bits;

   logic [31:0] mem [0:(2**ADDR_W)-1];

   // Upper address bits are intentionally dropped so addresses wrap modulo depth.
   assign unused_mar_bits = ^MAR[31:ADDR_W];

   assign commit_write = !reset && (state == BUSY) && (cnt == 4'd0) && !op_read;

   // NOTE: the array has no reset so it maps onto RAM; reset aborts a pending write via commit_write instead.
   always_ff @(posedge clk) begin
      if (commit_write)
         mem[addr_q] <= data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Mdatain <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (Read || Write) begin
                  addr_q  <= MAR[ADDR_W-1:0];
                  data_q  <= MDR;
                  op_read <= Read;
                  cnt     <= 4'(WAIT);
                  state   <= BUSY;
                  busy    <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (op_read)
                     Mdatain <= mem[addr_q];
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               // Leave only once the request type that started the access drops.
               if (!(op_read ? Read : Write)) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
